// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Holds the sequencer state encoding and the per-entry clear value.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    // Value the clear sweep loads into entry idx; caller truncates to the data width.
    function automatic int unsigned init_value(input int unsigned idx,
                                               input int unsigned init_r1,
                                               input int unsigned init_r2);
        int unsigned val;
        val = 0;
        if (idx == 1) begin
            val = init_r1;
        end else if (idx == 2) begin
            val = init_r2;
        end
        return val;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset or a clear request it walks every register index once,
// then reports the file ready. Owns the state and the sweep counter.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                ready,
    output logic                sweep_we,
    output logic [REG_ADDR-1:0] sweep_addr
);

    localparam logic [REG_ADDR-1:0] LastIdx = '1;

    rf_state_t           state_q, state_d;
    logic [REG_ADDR-1:0] cnt_q, cnt_d;
    logic                ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // No sweep write on a reset cycle, so a restart always begins cleanly at entry 0.
    assign sweep_we   = (state_q == CLEAR) && !rst;
    assign sweep_addr = cnt_q;
    assign ready      = ready_q;

endmodule

// File: rtl/regfile_multiport.sv
// RV32I integer register file: NUM_RD combinational read ports with write bypass,
// one synchronous write port, x0 reads as zero, swept to init values by the clear sequencer.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned REG_DATA = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned INIT_R1  = 20,
    parameter int unsigned INIT_R2  = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    input  logic [NUM_RD*REG_ADDR-1:0] rd_addr,
    output logic [NUM_RD*REG_DATA-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [REG_ADDR-1:0]        wr_addr,
    input  logic [REG_DATA-1:0]        wr_data,
    output logic                       ready
);

    localparam int unsigned Depth = 2 ** REG_ADDR;

    logic                sweep_we;
    logic [REG_ADDR-1:0] sweep_addr;

    regfile_clear_fsm #(
        .REG_ADDR (REG_ADDR)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .ready      (ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    logic [REG_DATA-1:0] mem_q [Depth];
    logic                port_we;
    logic                mem_we;
    logic [REG_ADDR-1:0] mem_waddr;
    logic [REG_DATA-1:0] mem_wdata;

    // A write coinciding with clr_req is dropped; the sweep would overwrite it anyway.
    assign port_we = ready && wr_en && !clr_req && !rst && (wr_addr != '0);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdata = REG_DATA'(init_value(32'(sweep_addr), INIT_R1, INIT_R2));
        end else if (port_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_ADDR-1:0] addr;
        logic [REG_DATA-1:0] rdata;

        assign addr = rd_addr[i*REG_ADDR +: REG_ADDR];

        always_comb begin
            rdata = '0;
            if (ready && (addr != '0)) begin
                if (wr_en && (wr_addr == addr)) begin
                    rdata = wr_data;
                end else begin
                    rdata = mem_q[addr];
                end
            end
        end

        assign rd_data[i*REG_DATA +: REG_DATA] = rdata;
    end

endmodule
